// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and address helper for the instruction-memory loader.
package imem_loader_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned LANE_W = 2;

   localparam logic [1:0]        ACCESS_WORD       = 2'b10;
   localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } ld_state_e;

   // Byte address of word number idx; idx is capped by MAX_WORDS so no wrap occurs.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: lane counter plus word buffer with clear and shift-in.
module imem_loader_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              shift_i,
   input  logic [BYTE_W-1:0] data_i,
   output logic [DATA_W-1:0] word_nxt_c,
   output logic              word_full_c
);

   logic [LANE_W-1:0] lane_q;
   logic [DATA_W-1:0] buf_q;

   // Buffer with the incoming byte merged into its lane; cleared lanes give the zero padding.
   always_comb begin
      word_nxt_c = buf_q;
      word_nxt_c[{lane_q, 3'b000} +: BYTE_W] = data_i;
   end

   assign word_full_c = shift_i && (lane_q == LANE_W'(3));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
         buf_q  <= '0;
      end else if (clear_i) begin
         lane_q <= '0;
         buf_q  <= '0;
      end else if (shift_i) begin
         lane_q <= lane_q + LANE_W'(1);
         buf_q  <= word_nxt_c;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Writes a streamed byte image into instruction memory as word stores and holds the CPU until done.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned       MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_w_enable,
   output logic [1:0]        mem_access_size,
   output logic              mem_rdun,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  words_written
);

   ld_state_e         state_q;
   logic              ready_q;
   logic              last_q;
   logic              wen_q;
   logic              hold_q;
   logic              done_q;
   logic              error_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  words_q;

   logic              accept_c;
   logic              start_go_c;
   logic              clear_c;
   logic              full_c;
   logic              at_cap_c;
   logic [DATA_W-1:0] word_nxt_c;

   assign accept_c   = byte_valid & ready_q;
   assign start_go_c = start & ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERROR));
   assign clear_c    = start_go_c | (state_q == ST_WRITE);
   assign at_cap_c   = (words_q == CNT_W'(MAX_WORDS));

   imem_loader_packer u_packer (
      .clk         (clk),
      .rst         (reset),
      .clear_i     (clear_c),
      .shift_i     (accept_c),
      .data_i      (byte_data),
      .word_nxt_c  (word_nxt_c),
      .word_full_c (full_c)
   );

   // Loader FSM; memory-port registers are loaded on entry to WRITE so the strobe cycle is clean.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         last_q  <= 1'b0;
         wen_q   <= 1'b0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         addr_q  <= BASE_ADDR;
         data_q  <= '0;
         words_q <= '0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (accept_c && (full_c || byte_last)) begin
                  state_q <= ST_WRITE;
                  ready_q <= 1'b0;
                  last_q  <= byte_last;
                  data_q  <= word_nxt_c;
                  addr_q  <= word_addr(BASE_ADDR, words_q);
                  wen_q   <= !at_cap_c;
               end
            end
            ST_WRITE: begin
               wen_q <= 1'b0;
               if (at_cap_c) begin
                  state_q <= ST_ERROR;
                  error_q <= 1'b1;
               end else begin
                  words_q <= words_q + CNT_W'(1);
                  if (last_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= ST_COLLECT;
                     ready_q <= 1'b1;
                  end
               end
            end
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_go_c) begin
                  state_q <= ST_COLLECT;
                  ready_q <= 1'b1;
                  last_q  <= 1'b0;
                  hold_q  <= 1'b1;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  words_q <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign byte_ready      = ready_q;
   assign mem_address     = addr_q;
   assign mem_data_in     = data_q;
   assign mem_w_enable    = wen_q;
   assign mem_access_size = ACCESS_WORD;
   assign mem_rdun        = 1'b0;
   assign cpu_hold        = hold_q;
   assign done            = done_q;
   assign error           = error_q;
   assign words_written   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for whole images plus reset, overflow and restart sequences.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_last = 1'b0;

   logic        byte_ready, mem_w_enable, mem_rdun, cpu_hold, done, error;
   logic [31:0] mem_address, mem_data_in;
   logic [1:0]  mem_access_size;
   logic [15:0] words_written;

   logic        s_ready, s_we, s_rdun, s_hold, s_done, s_error;
   logic [31:0] s_addr, s_data;
   logic [1:0]  s_size;
   logic [15:0] s_words;

   int errors = 0;
   int checks = 0;

   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   logic [31:0] s_wr_addr [64];
   logic [31:0] s_wr_data [64];
   int wr_cnt = 0;
   int s_cnt = 0;
   int rdy_viol = 0;

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
      .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_w_enable(mem_w_enable),
      .mem_access_size(mem_access_size), .mem_rdun(mem_rdun), .cpu_hold(cpu_hold),
      .done(done), .error(error), .words_written(words_written)
   );

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(2)) dut_small (
      .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .byte_ready(s_ready),
      .mem_address(s_addr), .mem_data_in(s_data), .mem_w_enable(s_we),
      .mem_access_size(s_size), .mem_rdun(s_rdun), .cpu_hold(s_hold),
      .done(s_done), .error(s_error), .words_written(s_words)
   );

   // Memory-side log of every write strobe from both instances.
   always @(negedge clk) begin
      if (mem_w_enable) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_address;
            wr_data[wr_cnt] = mem_data_in;
         end
         wr_cnt++;
         if (byte_ready) rdy_viol++;
      end
      if (s_we) begin
         if (s_cnt < 64) begin
            s_wr_addr[s_cnt] = s_addr;
            s_wr_data[s_cnt] = s_data;
         end
         s_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_w_enable", 32'(mem_w_enable), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_address", mem_address, BASE);
      chk("rst_data_in", mem_data_in, 32'd0);
      chk("rst_words", 32'(words_written), 32'd0);
      chk("rst_access_size", 32'(mem_access_size), 32'd2);
      chk("rst_rdun", 32'(mem_rdun), 32'd0);
   endtask

   // Start pulse with a competing byte offered in the same cycle; it must not be consumed.
   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      byte_valid = 1'b1;
      byte_data = 8'hEE;
      byte_last = 1'b1;
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("start_words", 32'(words_written), 32'd0);
      chk("start_done", 32'(done), 32'd0);
      chk("start_error", 32'(error), 32'd0);
      chk("start_ready", 32'(byte_ready), 32'd1);
   endtask

   task automatic send(input logic [95:0] bytes, input int n, input bit rnd,
                       input bit use_last, input bit sel_small);
      int i;
      int cyc;
      i = 0;
      cyc = 0;
      while (i < n && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (rnd && $urandom_range(0, 1) == 0) begin
            byte_valid = 1'b0;
            byte_last = 1'b0;
         end else begin
            byte_valid = 1'b1;
            byte_data = bytes[8*i +: 8];
            byte_last = use_last && (i == n - 1);
            if (sel_small ? s_ready : byte_ready) i++;
         end
      end
      @(negedge clk);
      byte_valid = 1'b0;
      byte_last = 1'b0;
      chk("bytes_accepted", 32'(i), 32'(n));
   endtask

   task automatic wait_end(input bit sel_small);
      int cyc;
      cyc = 0;
      while (!(sel_small ? s_error : done) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("end_reached", 32'(sel_small ? s_error : done), 32'd1);
   endtask

   typedef struct packed {
      logic [95:0] bytes;
      logic [7:0]  n;
      logic        rnd;
      logic [1:0]  nw;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int base;
      int sbase;

      vecs[0] = '{bytes: 96'h00000000_00100093_00000013, n: 8'd8, rnd: 1'b0, nw: 2'd2,
                  w0: 32'h0000_0013, w1: 32'h0010_0093};
      vecs[1] = '{bytes: 96'h00000000_00002211_DDCCBBAA, n: 8'd6, rnd: 1'b0, nw: 2'd2,
                  w0: 32'hDDCC_BBAA, w1: 32'h0000_2211};
      vecs[2] = '{bytes: 96'h5A, n: 8'd1, rnd: 1'b0, nw: 2'd1,
                  w0: 32'h0000_005A, w1: 32'h0};
      vecs[3] = '{bytes: 96'h00000000_00100093_00000013, n: 8'd8, rnd: 1'b1, nw: 2'd2,
                  w0: 32'h0000_0013, w1: 32'h0010_0093};

      repeat (2) @(negedge clk);
      check_reset_vals();
      reset = 1'b0;

      for (int v = 0; v < 4; v++) begin
         start_pulse();
         base = wr_cnt;
         send(vecs[v].bytes, int'(vecs[v].n), vecs[v].rnd, 1'b1, 1'b0);
         wait_end(1'b0);
         chk($sformatf("v%0d_nwrites", v), 32'(wr_cnt - base), 32'(vecs[v].nw));
         chk($sformatf("v%0d_addr0", v), wr_addr[base], BASE);
         chk($sformatf("v%0d_data0", v), wr_data[base], vecs[v].w0);
         if (vecs[v].nw == 2'd2) begin
            chk($sformatf("v%0d_addr1", v), wr_addr[base+1], BASE + 32'd4);
            chk($sformatf("v%0d_data1", v), wr_data[base+1], vecs[v].w1);
         end
         chk($sformatf("v%0d_words", v), 32'(words_written), 32'(vecs[v].nw));
         chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
         chk($sformatf("v%0d_cpu_hold", v), 32'(cpu_hold), 32'd0);
         chk($sformatf("v%0d_error", v), 32'(error), 32'd0);
      end

      // Reset after five bytes: first word stays written, nothing else follows.
      start_pulse();
      base = wr_cnt;
      send(vecs[0].bytes, 5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals();
      chk("abort_nwrites", 32'(wr_cnt - base), 32'd1);
      chk("abort_data0", wr_data[base], 32'h0000_0013);
      reset = 1'b0;
      start_pulse();
      base = wr_cnt;
      send(vecs[0].bytes, 8, 1'b0, 1'b1, 1'b0);
      wait_end(1'b0);
      chk("reload_nwrites", 32'(wr_cnt - base), 32'd2);
      chk("reload_addr0", wr_addr[base], BASE);
      chk("reload_data1", wr_data[base+1], 32'h0010_0093);

      // Overflow on the two-word instance; the full-size instance takes all three words.
      start_pulse();
      base = wr_cnt;
      sbase = s_cnt;
      send(96'h0C0B0A09_08070605_04030201, 12, 1'b0, 1'b1, 1'b1);
      wait_end(1'b1);
      wait_end(1'b0);
      chk("ovf_nwrites", 32'(s_cnt - sbase), 32'd2);
      chk("ovf_addr0", s_wr_addr[sbase], BASE);
      chk("ovf_data0", s_wr_data[sbase], 32'h0403_0201);
      chk("ovf_addr1", s_wr_addr[sbase+1], BASE + 32'd4);
      chk("ovf_data1", s_wr_data[sbase+1], 32'h0807_0605);
      chk("ovf_error", 32'(s_error), 32'd1);
      chk("ovf_cpu_hold", 32'(s_hold), 32'd1);
      chk("ovf_done", 32'(s_done), 32'd0);
      chk("ovf_words", 32'(s_words), 32'd2);
      chk("big_nwrites", 32'(wr_cnt - base), 32'd3);
      chk("big_addr2", wr_addr[base+2], BASE + 32'd8);
      chk("big_data2", wr_data[base+2], 32'h0C0B_0A09);
      chk("big_words", 32'(words_written), 32'd3);
      start_pulse();
      chk("ovf_clear_error", 32'(s_error), 32'd0);
      chk("ovf_clear_hold", 32'(s_hold), 32'd1);

      chk("ready_low_in_strobe", 32'(rdy_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
